// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises async_rst, holds all resets for a minimum width,
// then releases active-low channel resets in index order with a fixed gap.
module rst_seq_ctrl #(
    parameter int STAGES      = 2,
    parameter int NUM_CH      = 3,
    parameter int MIN_ASSERT  = 4,
    parameter int RELEASE_GAP = 3
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] sw_rst_mask,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_done
);

    localparam int CMAX = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] CNT_ASSERT_END = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] CNT_GAP_END    = CW'(RELEASE_GAP - 1);
    localparam logic [IW-1:0] LAST_CH        = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_RELEASE,
        S_RUN
    } state_t;

    logic [STAGES-1:0] sync;
    logic              sync_ok;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     ch_idx, ch_idx_nxt;
    logic [NUM_CH-1:0] rst_n_nxt;
    logic              seq_done_nxt;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) sync <= '0;
        else           sync <= {sync[STAGES-2:0], 1'b1};
    end

    assign sync_ok = sync[STAGES-1];

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state     <= S_ASSERT;
            cnt       <= '0;
            ch_idx    <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ch_idx    <= ch_idx_nxt;
            rst_n_out <= rst_n_nxt;
            seq_done  <= seq_done_nxt;
        end
    end

    // Channels left out of a soft-reset mask are still 1, so a release slot
    // simply sets its bit; no separate per-channel flag register is needed.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ch_idx_nxt   = ch_idx;
        rst_n_nxt    = rst_n_out;
        seq_done_nxt = seq_done;

        case (state)
            S_ASSERT: begin
                if (sync_ok) begin
                    if (cnt == CNT_ASSERT_END) begin
                        rst_n_nxt[0] = 1'b1;
                        cnt_nxt      = '0;
                        ch_idx_nxt   = IW'(1);
                        if (NUM_CH == 1) begin
                            state_nxt    = S_RUN;
                            seq_done_nxt = 1'b1;
                        end else begin
                            state_nxt    = S_RELEASE;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                if (cnt == CNT_GAP_END) begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (ch_idx == IW'(k)) rst_n_nxt[k] = 1'b1;
                    end
                    cnt_nxt    = '0;
                    ch_idx_nxt = ch_idx + 1'b1;
                    if (ch_idx == LAST_CH) begin
                        state_nxt    = S_RUN;
                        seq_done_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_RUN: begin
                if (sw_rst_req && (|sw_rst_mask)) begin
                    rst_n_nxt    = rst_n_out & ~sw_rst_mask;
                    seq_done_nxt = 1'b0;
                    cnt_nxt      = '0;
                    ch_idx_nxt   = '0;
                    state_nxt    = S_ASSERT;
                end
            end

            default: begin
                state_nxt = S_ASSERT;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default build plus a minimal single-channel build.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       async_rst, sw_rst_req;
    logic [2:0] sw_rst_mask, rst_n_out;
    logic       seq_done;

    logic       rst1, req1, done1;
    logic [0:0] mask1, rst1_n;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    rst_seq_ctrl #(.STAGES(2), .NUM_CH(3), .MIN_ASSERT(4), .RELEASE_GAP(3)) dut (
        .clk(clk), .async_rst(async_rst), .sw_rst_req(sw_rst_req),
        .sw_rst_mask(sw_rst_mask), .rst_n_out(rst_n_out), .seq_done(seq_done)
    );

    rst_seq_ctrl #(.STAGES(3), .NUM_CH(1), .MIN_ASSERT(1), .RELEASE_GAP(1)) dut1 (
        .clk(clk), .async_rst(rst1), .sw_rst_req(req1),
        .sw_rst_mask(mask1), .rst_n_out(rst1_n), .seq_done(done1)
    );

    typedef struct {
        int         dut;
        int         cyc;
        logic [2:0] rst;
        logic       done;
        string      name;
    } exp_t;

    exp_t q[$];

    // Expected outputs, checked at the falling edge after the numbered rising edge.
    initial begin : monitor
        exp_t       e;
        logic [2:0] ar;
        logic       ad;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    ar = rst_n_out;
                    ad = seq_done;
                end else begin
                    ar = {2'b00, rst1_n};
                    ad = done1;
                end
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: check for edge %0d reached at edge %0d", e.name, e.cyc, cyc);
                end else if (ar !== e.rst || ad !== e.done) begin
                    errors++;
                    $display("FAIL %s @edge %0d: got rst_n_out=%b seq_done=%b, required rst_n_out=%b seq_done=%b",
                             e.name, cyc, ar, ad, e.rst, e.done);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic push(input int d, input int c, input logic [2:0] r, input logic dn, input string nm);
        exp_t e;
        e.dut  = d;
        e.cyc  = c;
        e.rst  = r;
        e.done = dn;
        e.name = nm;
        q.push_back(e);
    endtask

    // Bit k of a masked channel rises MIN_ASSERT + k*RELEASE_GAP edges after T0.
    function automatic logic [2:0] pat(input int d, input logic [2:0] m);
        logic [2:0] b;
        for (int k = 0; k < 3; k++) b[k] = !m[k] || (d >= 4 + 3 * k);
        return b;
    endfunction

    task automatic push_seq(input int t0, input int d0, input int d1, input logic [2:0] m, input string nm);
        for (int d = d0; d <= d1; d++) push(0, t0 + d, pat(d, m), d >= 10, nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            step();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d checks still pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin : stim
        int c, t0, e;
        async_rst   = 1'b1;
        sw_rst_req  = 1'b0;
        sw_rst_mask = 3'b000;
        rst1        = 1'b1;
        req1        = 1'b0;
        mask1       = 1'b0;

        push(0, 1, 3'b000, 1'b0, "por_reset");
        push(1, 1, 3'b000, 1'b0, "por_reset_min");
        step(); step(); step();

        // Power-on; soft requests during RELEASE and with an empty mask must be ignored.
        c  = cyc;
        t0 = c + 2;
        async_rst = 1'b0;
        push(0, c + 1, 3'b000, 1'b0, "sync_wait");
        push_seq(t0, 0, 15, 3'b111, "power_on");
        wait_cyc(t0 + 4);
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b111;
        step();
        sw_rst_req  = 1'b0;
        wait_cyc(t0 + 11);
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b000;
        step();
        sw_rst_req  = 1'b0;
        drain();

        // Full-cycle reset pulse, then a sub-cycle glitch during RELEASE.
        c  = cyc;
        t0 = c + 3;
        push(0, c + 1, 3'b000, 1'b0, "async_hold");
        push(0, c + 2, 3'b000, 1'b0, "async_sync");
        push_seq(t0, 0, 4, 3'b111, "pre_glitch");
        async_rst = 1'b1;
        step();
        async_rst = 1'b0;
        wait_cyc(t0 + 4);
        push(0, t0 + 5, 3'b000, 1'b0, "glitch");
        push_seq(t0 + 6, 0, 12, 3'b111, "after_glitch");
        #1 async_rst = 1'b1;
        #2 async_rst = 1'b0;
        drain();

        // Soft reset of channels 1 and 2; channel 0 must stay high throughout.
        c = cyc;
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b110;
        push_seq(c + 1, 0, 12, 3'b110, "soft_110");
        step();
        sw_rst_req  = 1'b0;
        sw_rst_mask = 3'b000;
        drain();

        // Async reset while a soft sequence sits in ASSERT discards its mask.
        c = cyc;
        e = c + 1;
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b011;
        for (int i = 0; i < 3; i++) push(0, e + i, 3'b100, 1'b0, "soft_011");
        push(0, e + 3, 3'b000, 1'b0, "async_in_soft");
        push_seq(e + 4, 0, 12, 3'b111, "por_after_soft");
        step();
        sw_rst_req  = 1'b0;
        sw_rst_mask = 3'b000;
        step(); step();
        #1 async_rst = 1'b1;
        #2 async_rst = 1'b0;
        drain();

        // Minimal build: 3-stage sync, single channel released one edge after T0.
        c = cyc;
        rst1 = 1'b0;
        push(1, c + 1, 3'b000, 1'b0, "min_sync1");
        push(1, c + 2, 3'b000, 1'b0, "min_sync2");
        push(1, c + 3, 3'b000, 1'b0, "min_t0");
        push(1, c + 4, 3'b001, 1'b1, "min_release");
        push(1, c + 5, 3'b001, 1'b1, "min_run");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
